// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshake on both sides and carry/overflow/zero status flags.
//
// Stage 1 captures bitwise propagate/generate of A and the effective B
// operand (inverted for subtraction), plus the effective carry-in.
// Stage 2 resolves group and intra-group carries by lookahead, forms the sum
// and the flags, and holds them until the consumer takes them.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NGRP = WIDTH / GROUP;

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_adv;
  logic s2_adv;

  // Each stage may advance when it is empty or its successor makes room.
  // The ready path is purely combinational from out_ready (no skid buffer).
  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1: operand conditioning and bitwise propagate/generate
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;
  logic             c0_d;

  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] g_q;
  logic             c0_q;
  logic             a_msb_q;
  logic             b_msb_q;

  // Subtraction is A + ~B + 1, so the carry-in is forced high and in_cin
  // has no effect in that mode.
  assign b_eff = in_sub ? ~in_b : in_b;
  assign p_d   = in_a ^ b_eff;
  assign g_d   = in_a & b_eff;
  assign c0_d  = in_sub | in_cin;

  // Capture stage: data registers load only on an accepted operand set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      c0_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        p_q     <= p_d;
        g_q     <= g_d;
        c0_q    <= c0_d;
        a_msb_q <= in_a[WIDTH-1];
        b_msb_q <= b_eff[WIDTH-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: lookahead carry resolution
  // ---------------------------------------------------------------------------
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] carry_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [GROUP-1:0] gs;
      logic [GROUP-1:0] ps;
      logic [GROUP-1:0] cl;
      logic             gg;
      logic             gp;

      assign gs = g_q[gi*GROUP +: GROUP];
      assign ps = p_q[gi*GROUP +: GROUP];

      // Group generate as a flat OR of (g_j AND all higher p), group
      // propagate as the AND of all p in the group.
      always_comb begin
        logic term;
        gg   = 1'b0;
        gp   = 1'b1;
        term = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
          term = gs[j];
          for (int k = j + 1; k < GROUP; k++) begin
            term = term & ps[k];
          end
          gg = gg | term;
          gp = gp & ps[j];
        end
      end

      assign grp_g[gi] = gg;
      assign grp_p[gi] = gp;

      // Carry into each bit of the group, looked ahead from the group
      // carry-in rather than rippled bit to bit.
      always_comb begin
        logic term;
        logic chain;
        cl    = '0;
        term  = 1'b0;
        chain = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
          chain = grp_c[gi];
          for (int k = 0; k < i; k++) begin
            chain = chain & ps[k];
          end
          cl[i] = chain;
          for (int j = 0; j < i; j++) begin
            term = gs[j];
            for (int k = j + 1; k < i; k++) begin
              term = term & ps[k];
            end
            cl[i] = cl[i] | term;
          end
        end
      end

      assign carry_vec[gi*GROUP +: GROUP] = cl;
    end
  endgenerate

  // Group carry chain: c(k+1) = GG(k) | GP(k) & c(k). Kept in one block so
  // the chain is evaluated as a single combinational unit.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = c0_q;
    for (int k = 0; k < NGRP; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
  end

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;

  assign sum_d  = p_q ^ carry_vec;
  assign cout_d = grp_c[NGRP];
  // Signed overflow: operands of equal sign producing a result of the other
  // sign. This is the same condition as carry-into-MSB XOR carry-out-of-MSB.
  assign ovf_d  = ~(a_msb_q ^ b_msb_q) & (sum_d[WIDTH-1] ^ a_msb_q);
  assign zero_d = ~|sum_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  // Output stage: results are held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: a 32-bit/group-4 instance and an
// 8-bit/group-4 instance share the same handshake and the low byte of the
// operands. Expected results come from a plain-arithmetic model.
module tb_cla_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        in_cin;

  logic        in_ready32, out_valid32, out_cout32, out_ovf32, out_zero32;
  logic [31:0] out_sum32;
  logic        in_ready8, out_valid8, out_cout8, out_ovf8, out_zero8;
  logic [7:0]  out_sum8;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(32), .GROUP(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_sum(out_sum32), .out_cout(out_cout32), .out_ovf(out_ovf32), .out_zero(out_zero32)
  );

  cla_pipe_addsub #(.WIDTH(8), .GROUP(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(out_sum8), .out_cout(out_cout8), .out_ovf(out_ovf8), .out_zero(out_zero8)
  );

  typedef struct packed {
    logic [31:0] s32; logic c32; logic o32; logic z32;
    logic [7:0]  s8;  logic c8;  logic o8;  logic z8;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   applied  = 0;
  int   n_out    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: unsigned and signed integer arithmetic on w-bit operands.
  // Returns {sum[31:0], cout, ovf, zero}.
  function automatic logic [34:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic sub, input logic cin);
    longint full, mask, half, ua, ub, tot, sa, sb, res, sum;
    logic cout, ovf;
    full = longint'(1) << w;
    mask = full - 1;
    half = full >> 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    if (sub) begin
      tot  = ua - ub;
      cout = (ua >= ub);
    end else begin
      tot  = ua + ub + longint'(cin);
      cout = (tot >= full);
    end
    sum = tot & mask;
    sa  = (ua >= half) ? ua - full : ua;
    sb  = (ub >= half) ? ub - full : ub;
    res = sub ? (sa - sb) : (sa + sb + longint'(cin));
    ovf = (res >= half) || (res < -half);
    return {32'(sum), cout, ovf, (sum == 0)};
  endfunction

  // Stimulus side of the scoreboard: push the expected result on acceptance.
  always @(negedge clk) begin
    logic [34:0] r32, r8;
    exp_t e;
    if (rst_n) begin
      chk("in_ready_w8_vs_w32", {63'd0, in_ready8}, {63'd0, in_ready32});
      if (in_valid && in_ready32) begin
        r32 = ref_op(32, in_a, in_b, in_sub, in_cin);
        r8  = ref_op(8,  in_a, in_b, in_sub, in_cin);
        e.s32 = r32[34:3]; e.c32 = r32[2]; e.o32 = r32[1]; e.z32 = r32[0];
        e.s8  = r8[10:3];  e.c8  = r8[2];  e.o8  = r8[1];  e.z8  = r8[0];
        sbq.push_back(e);
        applied++;
      end
    end
  end

  // Monitor: pops and compares on every output transfer, and checks that a
  // stalled output is held unchanged.
  logic        prev_stall = 1'b0;
  logic [46:0] held;
  always @(negedge clk) begin
    exp_t e;
    logic [46:0] cur;
    cur = {out_valid32, out_sum32, out_cout32, out_ovf32, out_zero32,
           out_valid8, out_sum8, out_cout8, out_ovf8, out_zero8};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_while_stalled", {17'd0, cur}, {17'd0, held});
      if (out_valid32 || out_valid8)
        chk("out_valid_w8_vs_w32", {63'd0, out_valid8}, {63'd0, out_valid32});
      if (out_valid32 && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          n_out++;
          chk("result_w32", {29'd0, out_sum32, out_cout32, out_ovf32, out_zero32},
                            {29'd0, e.s32, e.c32, e.o32, e.z32});
          chk("result_w8", {53'd0, out_sum8, out_cout8, out_ovf8, out_zero8},
                           {53'd0, e.s8, e.c8, e.o8, e.z8});
          $display("[%0t] out #%0d sum32=%h c=%b v=%b z=%b | sum8=%h c=%b v=%b z=%b", $time, n_out,
                   out_sum32, out_cout32, out_ovf32, out_zero32, out_sum8, out_cout8, out_ovf8, out_zero8);
        end
      end
      prev_stall = out_valid32 && !out_ready;
      held = cur;
    end
  end

  // Present one operand set and hold it until accepted; returns at #1 after
  // the accepting edge with in_valid low.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic cin, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready32) begin ok = 1'b1; break; end
      waited++;
    end
    if (!ok) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Send into an empty pipeline and check the exact 2-cycle latency plus the
  // 32-bit result fields against hand-derived values.
  task automatic send_expect(input logic [31:0] a, input logic [31:0] b, input logic sub,
                             input logic cin, input logic [31:0] es, input logic ec,
                             input logic eo, input logic ez);
    int w;
    send(a, b, sub, cin, w);
    chk("latency_not_early", {63'd0, out_valid32}, 64'd0);
    @(posedge clk); #1;
    chk("latency_2_valid", {63'd0, out_valid32}, 64'd1);
    chk("directed_fields", {29'd0, out_sum32, out_cout32, out_ovf32, out_zero32},
                           {29'd0, es, ec, eo, ez});
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !out_valid32) break;
    end
    chk("drain_complete", {32'd0, 32'(sbq.size())}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    logic acc;
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid32}, 64'd0);
    chk("reset_out_fields", {29'd0, out_sum32, out_cout32, out_ovf32, out_zero32}, 64'd0);
    chk("reset_out8_fields", {54'd0, out_valid8, out_sum8, out_cout8, out_ovf8, out_zero8}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {63'd0, in_ready32}, 64'd1);

    // Wrap-around, overflow and subtract corner cases.
    send_expect(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_expect(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_expect(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    send_expect(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send_expect(32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_expect(32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 32'h1234_5679, 1'b0, 1'b0, 1'b0);
    wait_empty();

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      chk("burst_no_wait", 64'(w), 64'd0);
      chk("burst_out_valid", {63'd0, out_valid32}, (i >= 1) ? 64'd1 : 64'd0);
    end
    wait_empty();

    // Backpressure: consumer stalled while the producer keeps offering.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'b0; in_cin = 1'b1;
    @(negedge clk); chk("stall_ready_c1", {63'd0, in_ready32}, 64'd1);
    @(posedge clk); #1;
    in_a = $urandom; in_b = $urandom; in_sub = 1'b1;
    @(negedge clk); chk("stall_ready_c2", {63'd0, in_ready32}, 64'd1);
    @(posedge clk); #1;
    in_a = $urandom; in_b = $urandom; in_sub = 1'b0; in_cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("stall_ready_full", {63'd0, in_ready32}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid32}, 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); chk("release_ready", {63'd0, in_ready32}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_empty();

    // Reset with two operations in flight discards them.
    out_ready = 1'b0;
    send($urandom, $urandom, 1'b0, 1'b0, w);
    send($urandom, $urandom, 1'b1, 1'b0, w);
    chk("inflight_out_valid", {63'd0, out_valid32}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {62'd0, out_valid32, out_valid8}, 64'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_stale_after_reset", {63'd0, out_valid32}, 64'd0);
    end
    send_expect(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    wait_empty();

    // Random traffic with random producer gaps and consumer stalls.
    acc = 1'b0;
    cyc = 0;
    while (applied < 10000 && cyc < 40000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = $urandom; in_b = $urandom;
        in_sub = 1'($urandom_range(0, 1)); in_cin = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) in_b = in_a;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_valid && in_ready32;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("random_cycle_budget", 64'(cyc < 40000), 64'd1);
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", applied, n_errors);
    $finish;
  end

endmodule
